ip_responder: RTL
=================

# ip_responder

IP-side endpoint for the LWIP/SWIP custom-instruction path. It consumes the `datarw`/`dataena` strobes and the IP select produced by the instruction decoder. Writes (SWIP) are buffered in a small FIFO toward the attached IP core; reads (LWIP) are turned into a request/response transaction on the IP side, and the CPU pipeline is stalled until read data returns.

## Interface
- `DW`, 32: data width.
- `DEPTH`, 4: write FIFO depth; power of two, ≥2.
- `IP_ID`, 5'b00000: select code this instance responds to.
- `TIMEOUT`, 16: read timeout in cycles; used only with `IPRESP_TIMEOUT_EN`.
- `clk`  in  1  Clock. One clock domain; all logic rises on `clk`.
- `rst`  in  1  Reset, synchronous, active-high.
- `datarw`  in  1  Write request (SWIP).
- `dataena`  in  1  Read request (LWIP).
- `ip_sel`  in  5  Target IP select.
- `cpu_wdata`  in  DW  Store data.
- `rdata`  out  DW  Load data, registered.
- `rvalid`  out  1  One-cycle load-complete pulse.
- `stall`  out  1  Combinational; request presented but not completed this cycle.
- `err`  out  1  Sticky error; cleared only by `rst`.
- `ip_wdata`  out  DW  FIFO head.
- `ip_wvalid`  out  1  FIFO not empty.
- `ip_wready`  in  1  IP accepts head.
- `ip_rreq`  out  1  Read request to IP; level signal.
- `ip_rdata`  in  DW  IP read data.
- `ip_rvalid`  in  1  IP read data valid.

## Operation
- Hit = `ip_sel == IP_ID`. Non-hit requests are ignored: no stall, no state change.
- `dataena` and `datarw` both high on a hit: the read is serviced, the write is dropped, and `err` is set.
- Write, accepted when hit & `datarw` & FIFO not full & state IDLE:
  - Push `cpu_wdata`.
  - Full FIFO → `stall`=1 and no push, even if a pop occurs in the same cycle.
- FIFO:
  - Count width is clog2(DEPTH)+1. Read and write pointers wrap modulo DEPTH.
  - Pop when `ip_wvalid & ip_wready`.
  - Push and pop in the same cycle leave the count unchanged.
- Read FSM states: IDLE, DRAIN, RD_REQ, RESP.
  - IDLE: on a read hit → DRAIN if the FIFO is non-empty, else RD_REQ. `stall`=1.
  - DRAIN: wait for FIFO empty, which preserves read-after-write ordering, then → RD_REQ. `stall`=1.
  - RD_REQ: `ip_rreq`=1. On `ip_rvalid`, capture `ip_rdata` into `rdata` → RESP. `stall`=1.
  - RESP: `rvalid`=1, `stall`=0. The held LWIP retires this cycle and is not re-accepted → IDLE.
- While the FSM is not in IDLE, write hits stall.
- `rdata` holds its value until the next capture.

## Timing
- Reset values: `rdata`=0, `rvalid`=0, `err`=0, `ip_rreq`=0, `ip_wvalid`=0, FIFO empty, FSM in IDLE.
- Reset mid-operation: FIFO contents are discarded, `ip_rreq` drops the next cycle, and late `ip_rvalid` is ignored.
- Write accepted at cycle T → `ip_wvalid`=1 with that data at T+1.
- Read accepted at T with the FIFO empty:
  - `ip_rreq` is high from T+1.
  - `ip_rvalid` at cycle R → RESP and `rvalid` at R+1.
  - Minimum LWIP occupancy is 3 cycles: stall, stall, complete.
- `ip_rvalid` outside RD_REQ is ignored.
- `stall` is combinational from the inputs and state; there are no other combinational input-to-output paths.

## Configuration
- `IPRESP_TIMEOUT_EN` defined:
  - A counter runs in RD_REQ.
  - If no `ip_rvalid` arrives after TIMEOUT cycles, `rdata`=32'hDEADBEEF, `err` is set, FSM → RESP, and `ip_rreq` drops.
  - An `ip_rvalid` arriving in the same cycle as expiry wins.
- Undefined: RD_REQ waits indefinitely and no counter logic is built.

## Test plan
- Reset, then idle → all outputs 0 and `stall`=0.
- Five SWIP hits (data 1..5) with `ip_wready`=0 → four pushes and `stall`=1 on the fifth. Raise `ip_wready` → `ip_wdata` sequence 1,2,3,4, then the fifth is accepted.
- LWIP hit with the FIFO empty and `ip_rvalid` on the first `ip_rreq` cycle (`ip_rdata`=32'hA5A5_0001) → `stall` 1,1, then `rvalid`=1 with `rdata`=32'hA5A5_0001 at T+2.
- Two SWIPs followed by an LWIP → `ip_rreq` does not rise until both writes have popped.
- `ip_sel`=5'b00001 with `datarw`=1 → no push and no stall. `datarw`=`dataena`=1 on a hit → read serviced, no push, `err`=1.
- With `IPRESP_TIMEOUT_EN` and `ip_rvalid` never asserted → at 16 cycles, `rvalid`=1 with `rdata`=32'hDEADBEEF and `err`=1.

Source files
------------

// File: rtl/ip_responder.sv
// IP-side endpoint for LWIP/SWIP custom instructions: buffers stores toward the IP core and turns
// loads into a request/response handshake. Optional read timeout enabled by `IPRESP_TIMEOUT_EN.
module ip_responder #(
    parameter int          DW      = 32,
    parameter int          DEPTH   = 4,
    parameter logic [4:0]  IP_ID   = 5'b00000,
    parameter int          TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          datarw,
    input  logic          dataena,
    input  logic [4:0]    ip_sel,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] rdata,
    output logic          rvalid,
    output logic          stall,
    output logic          err,
    output logic [DW-1:0] ip_wdata,
    output logic          ip_wvalid,
    input  logic          ip_wready,
    output logic          ip_rreq,
    input  logic [DW-1:0] ip_rdata,
    input  logic          ip_rvalid
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_RD_REQ,
        S_RESP
    } state_t;

    state_t        state_reg;
    state_t        state_next;

    logic [DW-1:0] mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [DW-1:0] rdata_reg;
    logic          err_reg;

    logic          hit;
    logic          read_hit;
    logic          write_hit;
    logic          conflict;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          capture;
    logic          expire;
    logic          timeout_fire;

    assign hit        = (ip_sel == IP_ID);
    assign read_hit   = hit & dataena;
    // A simultaneous store is dropped; the load takes priority.
    assign write_hit  = hit & datarw & ~dataena;
    assign conflict   = hit & datarw & dataena;
    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign fifo_empty = (count_reg == '0);
    assign pop        = ip_wvalid & ip_wready;

    assign ip_wvalid  = ~fifo_empty;
    assign ip_wdata   = mem_reg[rd_ptr_reg];
    assign ip_rreq    = (state_reg == S_RD_REQ);
    assign rvalid     = (state_reg == S_RESP);
    assign rdata      = rdata_reg;
    assign err        = err_reg;

    always_comb begin
        state_next   = state_reg;
        stall        = 1'b0;
        push         = 1'b0;
        capture      = 1'b0;
        timeout_fire = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (read_hit) begin
                    stall      = 1'b1;
                    state_next = fifo_empty ? S_RD_REQ : S_DRAIN;
                end else if (write_hit) begin
                    if (fifo_full) begin
                        stall = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                stall = read_hit | write_hit;
                // Pending stores must reach the IP before the load is issued.
                if (fifo_empty) begin
                    state_next = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                stall = read_hit | write_hit;
                if (ip_rvalid) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end else if (expire) begin
                    timeout_fire = 1'b1;
                    state_next   = S_RESP;
                end
            end
            S_RESP: begin
                stall      = write_hit;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            rdata_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (capture) begin
                rdata_reg <= ip_rdata;
            end else if (timeout_fire) begin
                rdata_reg <= DW'(32'hDEADBEEF);
            end
            if (conflict || timeout_fire) begin
                err_reg <= 1'b1;
            end
        end
    end

`ifdef IPRESP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_reg;

    assign expire = (state_reg == S_RD_REQ) && (tmo_cnt_reg == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || state_reg != S_RD_REQ) begin
            tmo_cnt_reg <= '0;
        end else if (!expire) begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT != 0);
    assign expire         = 1'b0;
`endif

endmodule
